// File: rtl/csr_cmd_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_cmd_master_if
//  Description : Signal bundle between csr_cmd_master and its surroundings:
//                host rx byte link, host tx byte link and the CSR memory
//                interface, plus the busy flag.
//                  rx_valid_i/rx_data_i/rx_ready_o : host bytes in
//                  tx_valid_o/tx_data_o/tx_ready_i : response bytes out
//                  csr_addr_o/csr_ack_o/csr_data_o : CSR address, write strobe
//                                                    and write data
//                  csr_data_i                      : CSR read data (1-cycle)
//                  busy_o                          : master not idle
//                Modport master is used by csr_cmd_master; slave by the
//                environment that drives the links and models the CSR block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_cmd_master_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  rx_valid_i;
  logic [7:0]            rx_data_i;
  logic                  rx_ready_o;
  logic                  tx_valid_o;
  logic [7:0]            tx_data_o;
  logic                  tx_ready_i;
  logic [ADDR_WIDTH-1:0] csr_addr_o;
  logic                  csr_ack_o;
  logic [7:0]            csr_data_o;
  logic [7:0]            csr_data_i;
  logic                  busy_o;

  modport master (
    input  rx_valid_i, rx_data_i, tx_ready_i, csr_data_i,
    output rx_ready_o, tx_valid_o, tx_data_o, csr_addr_o, csr_ack_o,
           csr_data_o, busy_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, tx_ready_i, csr_data_i,
    input  rx_ready_o, tx_valid_o, tx_data_o, csr_addr_o, csr_ack_o,
           csr_data_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/csr_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : csr_cmd_master
//  Description : CSR bus initiator driven by a host byte-stream protocol.
//                Frame: CMD, ADDR_HI, ADDR_LO, LEN, then LEN data bytes for
//                writes (LEN of 0 means 256). 'W' (0x57) writes, 'R' (0x52)
//                reads and streams the read bytes back; any other command
//                answers '?' (0x3F). A completed write burst answers 'K'.
//  Ports       : clk, rst (synchronous, active-high)
//                bus : csr_cmd_master_if.master (rx link, tx link, CSR port,
//                      busy flag)
//  Options     : `define CSR_CMD_MASTER_TIMEOUT_EN aborts a frame with '?'
//                after TIMEOUT_CYCLES idle cycles while waiting for frame
//                bytes. Without it the master waits indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_cmd_master #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  csr_cmd_master_if.master  bus
);

  localparam logic [7:0]            c_cmd_write = 8'h57;
  localparam logic [7:0]            c_cmd_read  = 8'h52;
  localparam logic [7:0]            c_rsp_ok    = 8'h4B;
  localparam logic [7:0]            c_rsp_err   = 8'h3F;
  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_WDATA, S_WRITE,
    S_RADDR, S_RWAIT, S_RSEND, S_RESP, S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_rx_ready;
  logic                  w_rx_xfer;
  logic                  w_tx_xfer;
  logic                  w_last;
  logic                  w_timeout;

  logic                  r_is_write;
  logic [3:0]            r_addr_hi;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [8:0]            r_cnt;      // bytes remaining, 1..256
  logic [7:0]            r_wdata;
  logic                  r_tx_valid;
  logic [7:0]            r_tx_data;

  assign w_rx_xfer = bus.rx_valid_i & w_rx_ready;
  assign w_tx_xfer = r_tx_valid & bus.tx_ready_i;
  assign w_last    = (r_cnt == 9'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state and rx acceptance. rx_ready is held low while rst is asserted
  // so nothing is consumed during reset.
  always_comb begin
    w_next_state = r_state;
    w_rx_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rx_ready = ~rst;
        if (bus.rx_valid_i) begin
          if (bus.rx_data_i == c_cmd_write || bus.rx_data_i == c_cmd_read)
            w_next_state = S_ADDR_HI;
          else
            w_next_state = S_ERR;
        end
      end
      S_ADDR_HI: begin
        w_rx_ready = ~rst;
        if (bus.rx_valid_i) w_next_state = S_ADDR_LO;
      end
      S_ADDR_LO: begin
        w_rx_ready = ~rst;
        if (bus.rx_valid_i) w_next_state = S_LEN;
      end
      S_LEN: begin
        w_rx_ready = ~rst;
        if (bus.rx_valid_i) w_next_state = r_is_write ? S_WDATA : S_RADDR;
      end
      S_WDATA: begin
        w_rx_ready = ~rst;
        if (bus.rx_valid_i) w_next_state = S_WRITE;
      end
      S_WRITE: w_next_state = w_last ? S_RESP : S_WDATA;
      S_RADDR: w_next_state = S_RWAIT;
      S_RWAIT: w_next_state = S_RSEND;
      S_RSEND: begin
        if (w_tx_xfer) w_next_state = w_last ? S_IDLE : S_RADDR;
      end
      S_RESP, S_ERR: begin
        if (w_tx_xfer) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_timeout) w_next_state = S_ERR;
  end

  // Datapath. The address advances on leaving WRITE, so it is stable for the
  // whole strobe cycle; tx registers only move while idle or on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_write <= 1'b0;
      r_addr_hi  <= 4'd0;
      r_addr     <= '0;
      r_cnt      <= 9'd0;
      r_wdata    <= 8'd0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_xfer) begin
            r_is_write <= (bus.rx_data_i == c_cmd_write);
            if (bus.rx_data_i != c_cmd_write && bus.rx_data_i != c_cmd_read) begin
              r_tx_data  <= c_rsp_err;
              r_tx_valid <= 1'b1;
            end
          end
        end
        S_ADDR_HI: if (w_rx_xfer) r_addr_hi <= bus.rx_data_i[3:0];
        S_ADDR_LO: if (w_rx_xfer) r_addr <= ADDR_WIDTH'({r_addr_hi, bus.rx_data_i});
        S_LEN: begin
          if (w_rx_xfer)
            r_cnt <= (bus.rx_data_i == 8'd0) ? 9'd256 : {1'b0, bus.rx_data_i};
        end
        S_WDATA: if (w_rx_xfer) r_wdata <= bus.rx_data_i;
        S_WRITE: begin
          r_addr <= r_addr + c_addr_one;
          r_cnt  <= r_cnt - 9'd1;
          if (w_last) begin
            r_tx_data  <= c_rsp_ok;
            r_tx_valid <= 1'b1;
          end
        end
        S_RWAIT: begin
          r_tx_data  <= bus.csr_data_i;
          r_tx_valid <= 1'b1;
        end
        S_RSEND: begin
          if (w_tx_xfer) begin
            r_tx_valid <= 1'b0;
            r_addr     <= r_addr + c_addr_one;
            r_cnt      <= r_cnt - 9'd1;
          end
        end
        S_RESP, S_ERR: if (w_tx_xfer) r_tx_valid <= 1'b0;
        default: ;
      endcase
      if (w_timeout) begin
        r_tx_data  <= c_rsp_err;
        r_tx_valid <= 1'b1;
      end
    end
  end

`ifdef CSR_CMD_MASTER_TIMEOUT_EN
  localparam int                   c_tmo_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tmo_w-1:0]   c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_tmo_w-1:0]   c_tmo_one  = c_tmo_w'(1);

  logic [c_tmo_w-1:0] r_tmo;
  logic               w_tmo_state;

  // Only the states waiting on host bytes are timed.
  assign w_tmo_state = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) ||
                       (r_state == S_LEN)     || (r_state == S_WDATA);
  assign w_timeout   = w_tmo_state && !w_rx_xfer && (r_tmo == c_tmo_last);

  always_ff @(posedge clk) begin
    if (rst)
      r_tmo <= '0;
    else if (!w_tmo_state || w_rx_xfer || (w_next_state != r_state))
      r_tmo <= '0;
    else
      r_tmo <= r_tmo + c_tmo_one;
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  assign bus.rx_ready_o = w_rx_ready;
  assign bus.tx_valid_o = r_tx_valid;
  assign bus.tx_data_o  = r_tx_data;
  assign bus.csr_addr_o = r_addr;
  assign bus.csr_ack_o  = (r_state == S_WRITE);
  assign bus.csr_data_o = r_wdata;
  assign bus.busy_o     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_csr_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_cmd_master
//  Description : Self-checking bench for csr_cmd_master. Frames are modelled
//                as whole transactions: expected CSR writes and expected
//                response bytes are queued from the frame contents and a
//                reference memory image, then matched against the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_cmd_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_cmd_master_if #(.ADDR_WIDTH(12)) bus();

  csr_cmd_master #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [7:0]  data;
    logic        chk_addr;
    logic [11:0] addr;
  } tx_exp_t;

  tx_exp_t     exp_tx[$];
  logic [19:0] exp_wr[$];
  logic [7:0]  ref_mem [4096];
  logic [7:0]  csr_mem [4096];

  int   n_vec = 0;
  int   n_err = 0;
  int   bp_stalls = 0;
  logic bp_force = 1'b0;
  logic bp_rand  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    logic [11:0] aa;
    aa = 12'(a);
    return (aa[0] ? 8'h00 : 8'hFF) ^ {aa[11:8], aa[11:8]};
  endfunction

  // CSR block: registered read, write on strobe
  always @(posedge clk) begin
    if (bus.csr_ack_o) csr_mem[bus.csr_addr_o] <= bus.csr_data_o;
    bus.csr_data_i <= csr_mem[bus.csr_addr_o];
  end

  // Transmitter ready
  initial begin
    bus.tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready_i = bp_force ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor
  logic        prev_txv, prev_txr, prev_ack, prev_rxx;
  logic [7:0]  prev_txd;
  logic [11:0] prev_addr;

  always @(negedge clk) begin
    if (rst) begin
      prev_txv <= 1'b0; prev_txr <= 1'b0; prev_ack <= 1'b0; prev_rxx <= 1'b0;
      prev_txd <= 8'd0; prev_addr <= 12'd0;
    end else begin
      if (prev_txv && !prev_txr) begin
        bp_stalls++;
        check_val("bp_valid_hold", bus.tx_valid_o, 1);
        check_val("bp_data_hold", bus.tx_data_o, prev_txd);
        check_val("bp_addr_hold", bus.csr_addr_o, prev_addr);
      end
      if (bus.csr_ack_o) begin
        check_val("ack_single_cycle", prev_ack, 0);
        check_val("ack_after_wdata", prev_rxx, 1);
        if (exp_wr.size() == 0) check_val("ack_unexpected", bus.csr_ack_o, 0);
        else check_val("csr_write_addr_data", {bus.csr_addr_o, bus.csr_data_o}, exp_wr.pop_front());
      end
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        if (exp_tx.size() == 0) check_val("tx_unexpected", bus.tx_valid_o, 0);
        else begin
          tx_exp_t e;
          e = exp_tx.pop_front();
          check_val("tx_byte", bus.tx_data_o, e.data);
          if (e.chk_addr) check_val("read_addr", bus.csr_addr_o, e.addr);
        end
      end
      prev_txv  <= bus.tx_valid_o;
      prev_txr  <= bus.tx_ready_i;
      prev_txd  <= bus.tx_data_o;
      prev_addr <= bus.csr_addr_o;
      prev_ack  <= bus.csr_ack_o;
      prev_rxx  <= bus.rx_valid_i && bus.rx_ready_o;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic gaps);
    int n = 0;
    int k;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    do begin @(negedge clk); n++; end while (!bus.rx_ready_o && n < 5000);
    if (n >= 5000) check_val("rx_accept_timeout", bus.rx_ready_o, 1);
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'($urandom);
    k = gaps ? $urandom_range(0, 2) : 0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.rx_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val({tag, "_rx_ready"}, bus.rx_ready_o, 0);
    check_val({tag, "_tx_valid"}, bus.tx_valid_o, 0);
    check_val({tag, "_tx_data"},  bus.tx_data_o, 0);
    check_val({tag, "_csr_addr"}, bus.csr_addr_o, 0);
    check_val({tag, "_csr_ack"},  bus.csr_ack_o, 0);
    check_val({tag, "_csr_data"}, bus.csr_data_o, 0);
    check_val({tag, "_busy"},     bus.busy_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val({tag, "_idle_ready"}, bus.rx_ready_o, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (n < 5000 && !(exp_tx.size() == 0 && exp_wr.size() == 0 && !bus.busy_o));
    check_val({tag, "_busy"}, bus.busy_o, 0);
    check_val({tag, "_pending"}, exp_tx.size() + exp_wr.size(), 0);
    check_val({tag, "_tx_valid"}, bus.tx_valid_o, 0);
    exp_tx.delete();
    exp_wr.delete();
    @(posedge clk);
    #1;
  endtask

  // Model the frame as a transaction, then drive it byte by byte.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [11:0] addr,
                           input logic [7:0] len, input logic fixed,
                           input logic [7:0] d0, input logic [7:0] d1, input logic gaps);
    int          n;
    logic [7:0]  wd[$];
    logic [11:0] a;
    n = (len == 8'd0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) wd.push_back(fixed ? ((i == 0) ? d0 : d1) : 8'($urandom));
    if (cmd == 8'h57) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 12'(i);
        exp_wr.push_back({a, wd[i]});
        ref_mem[a] = wd[i];
      end
      exp_tx.push_back('{data: 8'h4B, chk_addr: 1'b0, addr: 12'd0});
    end else if (cmd == 8'h52) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 12'(i);
        exp_tx.push_back('{data: ref_mem[a], chk_addr: 1'b1, addr: a});
      end
    end else begin
      exp_tx.push_back('{data: 8'h3F, chk_addr: 1'b0, addr: 12'd0});
    end
    send_byte(cmd, gaps);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      send_byte({4'($urandom), addr[11:8]}, gaps);
      send_byte(addr[7:0], gaps);
      send_byte(len, gaps);
      if (cmd == 8'h57) for (int i = 0; i < n; i++) send_byte(wd[i], gaps);
    end
    wait_idle(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sel;
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [11:0] addr;

    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'd0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = init_val(i);
      csr_mem[i] = init_val(i);
    end

    apply_reset("reset");

    // Single write, burst read, wrapping write, 256-byte read
    run_frame("wr1", 8'h57, 12'h400, 8'd1, 1'b1, 8'h01, 8'h00, 1'b0);
    run_frame("rd4", 8'h52, 12'h000, 8'd4, 1'b0, 8'h00, 8'h00, 1'b0);
    run_frame("wrap", 8'h57, 12'hFFF, 8'd2, 1'b1, 8'hAA, 8'hBB, 1'b0);
    run_frame("rdwrap", 8'h52, 12'hFFF, 8'd2, 1'b0, 8'h00, 8'h00, 1'b0);
    run_frame("rd256", 8'h52, 12'(($urandom)), 8'd0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Back-pressure on a 2-byte read
    bp_stalls = 0;
    bp_force  = 1'b1;
    fork
      begin
        int m = 0;
        while (!bus.tx_valid_o && m < 200) begin @(negedge clk); m++; end
        repeat (10) @(negedge clk);
        bp_force = 1'b0;
      end
    join_none
    run_frame("bp", 8'h52, 12'h123, 8'd2, 1'b0, 8'h00, 8'h00, 1'b0);
    check_val("bp_stall_cycles", bp_stalls >= 10, 1);

    // Bad command
    run_frame("badcmd", 8'h41, 12'h000, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of a write burst after one strobe
    exp_wr.push_back({12'h600, 8'hAA});
    ref_mem[12'h600] = 8'hAA;
    send_byte(8'h57, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    for (int i = 0; i < 50 && exp_wr.size() != 0; i++) @(negedge clk);
    check_val("midrst_first_strobe", exp_wr.size(), 0);
    apply_reset("midrst");
    repeat (20) @(posedge clk);
    #1;
    check_val("midrst_no_tx", bus.tx_valid_o, 0);
    check_val("midrst_busy", bus.busy_o, 0);
    run_frame("postrst_rd", 8'h52, 12'h600, 8'd2, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random frames with random gaps and back-pressure
    bp_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      sel  = $urandom_range(0, 9);
      addr = ($urandom_range(0, 3) == 0) ? (12'hFFC + 12'($urandom_range(0, 3))) : 12'($urandom);
      len  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      if (sel == 0) begin
        do cmd = 8'($urandom); while (cmd == 8'h57 || cmd == 8'h52);
      end else begin
        cmd = (sel < 5) ? 8'h57 : 8'h52;
      end
      run_frame("rand", cmd, addr, len, 1'b0, 8'h00, 8'h00, 1'b1);
    end
    bp_rand = 1'b0;

`ifdef CSR_CMD_MASTER_TIMEOUT_EN
    begin
      int n = 0;
      exp_tx.push_back('{data: 8'h3F, chk_addr: 1'b0, addr: 12'd0});
      send_byte(8'h57, 1'b0);
      send_byte(8'h06, 1'b0);
      while (n < 100) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        if (bus.tx_valid_o) break;
      end
      check_val("timeout_latency", n, 16);
      wait_idle("timeout");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
